// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: picks the next obstacle after each idle gap and launches it.
// It never picks the same slot twice in a row. Then it waits for that slot's done
// pulse, or gives up after a timeout. All outputs are registered.
module obstacle_scheduler #(
    parameter int unsigned N_OBST         = 4,
    parameter int unsigned GAP_CYCLES     = 32000000,
    parameter int unsigned TIMEOUT_CYCLES = 200000000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              play_selected,
    input  logic              menu_on,
    input  logic [N_OBST-1:0] obst_done,
    output logic [N_OBST-1:0] selected,
    output logic              done_control,
    output logic              busy,
    output logic              timeout,
    output logic [7:0]        cleared_count
);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        LAUNCH,
        WAIT_DONE
    } state_t;

    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [24:0] GAP_LAST = 25'(GAP_CYCLES - 1);
    localparam logic [27:0] TO_LAST  = 28'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [24:0]       gap_cnt, gap_cnt_nxt;
    logic [27:0]       to_cnt, to_cnt_nxt;
    logic [15:0]       lfsr;
    logic [1:0]        last_idx, last_idx_nxt;
    logic [1:0]        cur_idx, cur_idx_nxt;
    logic [1:0]        pick;
    logic              abort;
    logic [N_OBST-1:0] selected_nxt;
    logic              done_control_nxt;
    logic              busy_nxt;
    logic              timeout_nxt;
    logic [7:0]        cleared_count_nxt;

    // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every cycle
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            to_cnt        <= '0;
            last_idx      <= 2'd3;
            cur_idx       <= '0;
            selected      <= '0;
            done_control  <= 1'b0;
            busy          <= 1'b0;
            timeout       <= 1'b0;
            cleared_count <= '0;
        end else begin
            state         <= state_nxt;
            gap_cnt       <= gap_cnt_nxt;
            to_cnt        <= to_cnt_nxt;
            last_idx      <= last_idx_nxt;
            cur_idx       <= cur_idx_nxt;
            selected      <= selected_nxt;
            done_control  <= done_control_nxt;
            busy          <= busy_nxt;
            timeout       <= timeout_nxt;
            cleared_count <= cleared_count_nxt;
        end
    end

    // Next-state and next-output logic; priority abort > done > timeout > gap expiry
    always_comb begin
        state_nxt         = state;
        gap_cnt_nxt       = gap_cnt;
        to_cnt_nxt        = to_cnt;
        last_idx_nxt      = last_idx;
        cur_idx_nxt       = cur_idx;
        selected_nxt      = selected;
        done_control_nxt  = 1'b0;
        timeout_nxt       = 1'b0;
        cleared_count_nxt = cleared_count;

        abort = menu_on || !play_selected;
        // Bump a repeated pick to the next slot; the 2-bit add wraps 3 -> 0
        pick  = (lfsr[1:0] == last_idx) ? lfsr[1:0] + 2'd1 : lfsr[1:0];

        if (state != IDLE && abort) begin
            state_nxt    = IDLE;
            selected_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    selected_nxt = '0;
                    if (play_selected && !menu_on) begin
                        state_nxt         = GAP;
                        cleared_count_nxt = '0;
                        gap_cnt_nxt       = '0;
                    end
                end
                GAP: begin
                    selected_nxt = '0;
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt          = LAUNCH;
                        cur_idx_nxt        = pick;
                        selected_nxt       = '0;
                        selected_nxt[pick] = 1'b1;
                        done_control_nxt   = 1'b1;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 25'd1;
                    end
                end
                LAUNCH: begin
                    state_nxt  = WAIT_DONE;
                    to_cnt_nxt = '0;
                end
                WAIT_DONE: begin
                    if (obst_done[cur_idx]) begin
                        state_nxt         = GAP;
                        gap_cnt_nxt       = '0;
                        last_idx_nxt      = cur_idx;
                        selected_nxt      = '0;
                        cleared_count_nxt = (cleared_count != 8'hFF) ? cleared_count + 8'd1
                                                                     : cleared_count;
                    end else if (to_cnt == TO_LAST) begin
                        state_nxt    = GAP;
                        gap_cnt_nxt  = '0;
                        last_idx_nxt = cur_idx;
                        selected_nxt = '0;
                        timeout_nxt  = 1'b1;
                    end else begin
                        to_cnt_nxt = to_cnt + 28'd1;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    selected_nxt = '0;
                end
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler with small gap/timeout values.
module tb_obstacle_scheduler;

    localparam int unsigned GAP  = 4;
    localparam int unsigned TOUT = 20;
    localparam logic [15:0] SEED = 16'h0001;

    logic       pclk;
    logic       rst;
    logic       play_selected;
    logic       menu_on;
    logic [3:0] obst_done;
    logic [3:0] selected;
    logic       done_control;
    logic       busy;
    logic       timeout;
    logic [7:0] cleared_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_last;
    int exp_count;

    // Reference LFSR: m_at_edge holds the value the design used at the latest edge
    logic [15:0] m_lfsr;
    logic [15:0] m_at_edge;

    obstacle_scheduler #(
        .N_OBST(4),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TOUT),
        .LFSR_SEED(SEED)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .play_selected(play_selected),
        .menu_on(menu_on),
        .obst_done(obst_done),
        .selected(selected),
        .done_control(done_control),
        .busy(busy),
        .timeout(timeout),
        .cleared_count(cleared_count)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always @(posedge pclk or negedge rst) begin
        if (!rst) begin
            m_lfsr    <= SEED;
            m_at_edge <= SEED;
        end else begin
            m_at_edge <= m_lfsr;
            m_lfsr    <= lfsr_step(m_lfsr);
        end
    end

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int model_pick(input logic [15:0] l, input int last);
        int p;
        p = int'(l[1:0]);
        if (p == last) p = (p + 1) % 4;
        return p;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Starts just after the edge that entered GAP; ends just after WAIT_DONE entry
    task automatic wait_launch(output int pick);
        for (int i = 1; i < int'(GAP); i++) begin
            tick();
            n_checks++;
            if ({busy, done_control, timeout, selected} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
                n_fail++;
                $display("FAIL gap_idle: got busy/dc/to/sel=%b expected 1_0_0_0000",
                         {busy, done_control, timeout, selected});
            end
        end
        tick();
        pick = model_pick(m_at_edge, exp_last);
        n_checks++;
        if ({done_control, selected} !== {1'b1, onehot(pick)}) begin
            n_fail++;
            $display("FAIL launch: got dc/sel=%b expected %b",
                     {done_control, selected}, {1'b1, onehot(pick)});
        end
        tick();
        n_checks++;
        if ({done_control, timeout, selected} !== {1'b0, 1'b0, onehot(pick)}) begin
            n_fail++;
            $display("FAIL launch_end: got dc/to/sel=%b expected %b",
                     {done_control, timeout, selected}, {2'b00, onehot(pick)});
        end
    endtask

    task automatic finish_done(input int delay, input int pick);
        for (int i = 0; i < delay; i++) begin
            tick();
            n_checks++;
            if ({timeout, selected} !== {1'b0, onehot(pick)}) begin
                n_fail++;
                $display("FAIL wait_hold: got to/sel=%b expected %b",
                         {timeout, selected}, {1'b0, onehot(pick)});
            end
        end
        obst_done = onehot(pick);
        tick();
        obst_done = '0;
        exp_last  = pick;
        exp_count = (exp_count < 255) ? exp_count + 1 : 255;
        n_checks++;
        if ({busy, done_control, timeout, selected, cleared_count} !==
            {1'b1, 1'b0, 1'b0, 4'b0000, 8'(exp_count)}) begin
            n_fail++;
            $display("FAIL done_accept: got sel=%b cnt=%0d expected sel=0000 cnt=%0d",
                     selected, cleared_count, exp_count);
        end
    endtask

    task automatic finish_timeout(input int pick);
        obst_done = onehot((pick + 1) % 4) | onehot((pick + 2) % 4);
        for (int i = 1; i < int'(TOUT); i++) begin
            tick();
            n_checks++;
            if ({timeout, selected} !== {1'b0, onehot(pick)}) begin
                n_fail++;
                $display("FAIL timeout_wait: got to/sel=%b expected %b",
                         {timeout, selected}, {1'b0, onehot(pick)});
            end
        end
        tick();
        obst_done = '0;
        exp_last  = pick;
        n_checks++;
        if ({timeout, selected, cleared_count} !== {1'b1, 4'b0000, 8'(exp_count)}) begin
            n_fail++;
            $display("FAIL timeout_pulse: got to=%b sel=%b cnt=%0d expected to=1 sel=0000 cnt=%0d",
                     timeout, selected, cleared_count, exp_count);
        end
    endtask

    task automatic test_reset_initial();
        rst = 1'b0; play_selected = 1'b0; menu_on = 1'b0; obst_done = '0;
        exp_last = 3; exp_count = 0;
        repeat (3) tick();
        rst = 1'b1;
        n_checks++;
        if ({selected, done_control, busy, timeout, cleared_count} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected 0000",
                     {selected, done_control, busy, timeout, cleared_count});
        end
        repeat (3) begin
            tick();
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_busy: got %b expected 0", busy);
            end
        end
    endtask

    task automatic start_game();
        play_selected = 1'b1;
        tick();
        exp_count = 0;
        n_checks++;
        if ({busy, selected, cleared_count} !== {1'b1, 4'b0000, 8'd0}) begin
            n_fail++;
            $display("FAIL game_start: got busy=%b sel=%b cnt=%0d expected 1 0000 0",
                     busy, selected, cleared_count);
        end
    endtask

    task automatic test_normal_round();
        int p;
        start_game();
        wait_launch(p);
        finish_done(10, p);
    endtask

    task automatic test_timeout();
        int p;
        wait_launch(p);
        finish_timeout(p);
        wait_launch(p);
        finish_done(0, p);
    endtask

    task automatic test_abort();
        int p;
        wait_launch(p);
        menu_on   = 1'b1;
        obst_done = onehot(p);
        tick();
        menu_on   = 1'b0;
        obst_done = '0;
        n_checks++;
        if ({busy, done_control, timeout, selected, cleared_count} !==
            {1'b0, 1'b0, 1'b0, 4'b0000, 8'(exp_count)}) begin
            n_fail++;
            $display("FAIL abort: got busy=%b sel=%b cnt=%0d expected 0 0000 %0d",
                     busy, selected, cleared_count, exp_count);
        end
        tick();
        exp_count = 0;
        n_checks++;
        if ({busy, cleared_count} !== {1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL restart: got busy=%b cnt=%0d expected 1 0", busy, cleared_count);
        end
    endtask

    task automatic test_no_repeat();
        int p;
        logic [3:0] prev_sel;
        logic [3:0] seen;
        prev_sel = '0;
        seen     = '0;
        for (int r = 0; r < 64; r++) begin
            wait_launch(p);
            n_checks++;
            if (selected === prev_sel) begin
                n_fail++;
                $display("FAIL no_repeat: round %0d got sel=%b same as previous", r, selected);
            end
            prev_sel = selected;
            seen     = seen | selected;
            finish_done(0, p);
        end
        n_checks++;
        if ({seen, cleared_count} !== {4'hF, 8'd64}) begin
            n_fail++;
            $display("FAIL coverage_count: got seen=%b cnt=%0d expected 1111 64",
                     seen, cleared_count);
        end
    endtask

    task automatic test_saturation();
        int p;
        for (int r = 64; r < 260; r++) begin
            wait_launch(p);
            finish_done(0, p);
        end
        n_checks++;
        if (cleared_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation: got %0d expected 255", cleared_count);
        end
    endtask

    task automatic test_reset();
        int p;
        wait_launch(p);
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({selected, done_control, busy, timeout, cleared_count} !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0000",
                     {selected, done_control, busy, timeout, cleared_count});
        end
        play_selected = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        exp_last  = 3;
        exp_count = 0;
        repeat (3) begin
            tick();
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_busy: got %b expected 0", busy);
            end
        end
        start_game();
        wait_launch(p);
        finish_done(3, p);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset_initial();
        test_normal_round();
        test_timeout();
        test_abort();
        test_no_repeat();
        test_saturation();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
